// File: rtl/adc_scan_sequencer.sv
// Scan controller for the LTC2308 measurement core: converts each enabled channel in
// ascending order, one at a time, and streams tagged results over valid/ready.
module adc_scan_sequencer #(
  parameter int NUM_CH         = 8,
  parameter int DATA_W         = 12,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              scan_trigger,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [GAP_W-1:0]  scan_gap,
  output logic              measure_start,
  output logic [2:0]        measure_ch,
  input  logic              measure_done,
  input  logic [DATA_W-1:0] measure_dataread,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_ch,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout,
  output logic [2:0]        timeout_ch
);

  localparam int CH_W = 3;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SETTLE,
    S_WAIT_DONE,
    S_PUSH,
    S_GAP
  } state_t;

  state_t            state, state_n;
  logic [NUM_CH-1:0] scan_mask;
  logic [CH_W-1:0]   cur_ch;
  logic [TO_W-1:0]   wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic              has_next;
  logic              load_scan, adv_ch, capture, to_hit, load_gap, end_of_ch;

  // Lowest set bit of the incoming mask, and the next set bit above the current channel.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (ch_mask[i]) first_ch = CH_W'(i);
  end

  always_comb begin
    nxt_ch   = cur_ch;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (scan_mask[i] && i > int'(cur_ch)) begin
        nxt_ch   = CH_W'(i);
        has_next = 1'b1;
      end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    load_scan = 1'b0;
    adv_ch    = 1'b0;
    capture   = 1'b0;
    to_hit    = 1'b0;
    load_gap  = 1'b0;
    end_of_ch = 1'b0;
    case (state)
      S_IDLE:
        if ((enable || scan_trigger) && |ch_mask) begin
          load_scan = 1'b1;
          state_n   = S_START;
        end
      S_START:  state_n = S_SETTLE;
      S_SETTLE: state_n = S_WAIT_DONE;
      S_WAIT_DONE:
        if (measure_done) begin
          capture = 1'b1;
          state_n = S_PUSH;
        end else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_hit    = 1'b1;
          end_of_ch = 1'b1;
        end
      S_PUSH:
        if (out_ready) end_of_ch = 1'b1;
      S_GAP:
        if (!enable) begin
          state_n = S_IDLE;
        end else if (gap_cnt == '0) begin
          if (|ch_mask) begin
            load_scan = 1'b1;
            state_n   = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      default: state_n = S_IDLE;
    endcase

    // A channel finishes either by handshake or by timeout; both continue the scan the same way.
    if (end_of_ch) begin
      if (has_next) begin
        adv_ch  = 1'b1;
        state_n = S_START;
      end else if (enable) begin
        load_gap = 1'b1;
        state_n  = S_GAP;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_mask   <= '0;
      cur_ch      <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      out_data    <= '0;
      out_ch      <= '0;
      out_last    <= 1'b0;
      err_timeout <= 1'b0;
      timeout_ch  <= '0;
    end else begin
      if (load_scan) begin
        scan_mask <= ch_mask;
        cur_ch    <= first_ch;
      end else if (adv_ch) begin
        cur_ch <= nxt_ch;
      end

      wait_cnt <= (state == S_WAIT_DONE) ? wait_cnt + TO_W'(1) : '0;

      if (load_gap)                          gap_cnt <= scan_gap;
      else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);

      if (capture) begin
        out_data <= measure_dataread;
        out_ch   <= cur_ch;
        out_last <= !has_next;
      end

      if (to_hit) begin
        err_timeout <= 1'b1;
        timeout_ch  <= cur_ch;
      end
    end
  end

  assign measure_start = (state == S_START);
  assign measure_ch    = cur_ch;
  assign out_valid     = (state == S_PUSH);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: behavioural ADC core model, expected-result
// queue filled from the scan rules, and an independent monitor comparing each handshake.
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        scan_trigger = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [15:0] scan_gap = '0;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done = 1'b0;
  logic [11:0] measure_dataread = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic [2:0]  out_ch;
  logic        out_last;
  logic        busy;
  logic        err_timeout;
  logic [2:0]  timeout_ch;

  adc_scan_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .scan_trigger     (scan_trigger),
    .ch_mask          (ch_mask),
    .scan_gap         (scan_gap),
    .measure_start    (measure_start),
    .measure_ch       (measure_ch),
    .measure_done     (measure_done),
    .measure_dataread (measure_dataread),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_ch           (out_ch),
    .out_last         (out_last),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .timeout_ch       (timeout_ch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
    logic        last;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [11:0] adc_data [8];
  logic [7:0]  bad_mask = '0;
  int          adc_lat = 77;
  bit          rand_lat = 1'b0;
  bit          rand_ready = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required event never seen (cycle %0d)", name, cyc);
  endtask

  // Reference model: one result per enabled, responsive channel, ascending; last = top enabled bit.
  function automatic void push_scan(input logic [7:0] mask);
    int top;
    pkt_t p;
    top = -1;
    for (int i = 0; i < 8; i++) if (mask[i]) top = i;
    for (int i = 0; i < 8; i++)
      if (mask[i] && !bad_mask[i]) begin
        p.ch   = 3'(i);
        p.data = adc_data[i];
        p.last = (i == top);
        exp_q.push_back(p);
      end
  endfunction

  // ADC core model: done stays high from the previous conversion until well after the next start.
  initial begin : adc_model
    int cnt;
    int lat;
    bit pend;
    logic [2:0] ch;
    cnt = 0; lat = 4; pend = 1'b0; ch = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        measure_done = 1'b0;
      end else if (measure_start) begin
        ch   = measure_ch;
        cnt  = 1;
        pend = 1'b1;
        lat  = rand_lat ? int'($urandom_range(4, 30)) : adc_lat;
      end else if (pend) begin
        cnt++;
        if (cnt == 3) measure_done = 1'b0;
        if (cnt >= lat && !bad_mask[ch]) begin
          measure_done     = 1'b1;
          measure_dataread = adc_data[ch];
          pend             = 1'b0;
        end
      end
    end
  end

  initial begin : ready_noise
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: result ordering/payload, payload hold under backpressure, and start spacing.
  initial begin : monitor
    bit   prev_stall;
    pkt_t prev_pkt;
    pkt_t e;
    int   hs_cyc;
    int   pending_dist;
    prev_stall = 1'b0; prev_pkt = '0; hs_cyc = 0; pending_dist = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall   = 1'b0;
        pending_dist = 0;
      end else begin
        if (!busy) pending_dist = 0;
        if (measure_start && pending_dist != 0) begin
          check("start_spacing", cyc - hs_cyc, pending_dist);
          pending_dist = 0;
        end
        if (prev_stall)
          check("stall_hold", {out_valid, out_ch, out_data, out_last, measure_start},
                {1'b1, prev_pkt, 1'b0});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: ch=%0d data=%h last=%0d, required no result",
                     out_ch, out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check("result", {out_ch, out_data, out_last}, e);
          end
          pops++;
          hs_cyc       = cyc;
          pending_dist = !out_last ? 1 : (enable ? int'(scan_gap) + 2 : 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_pkt   = {out_ch, out_data, out_last};
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      expired(name);
      exp_q.delete();
    end
    sync();
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) expired(name);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!measure_start && n < budget);
    if (n >= budget) expired(name);
    sync();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < budget);
    if (n >= budget) expired(name);
  endtask

  task automatic trigger_scan(input logic [7:0] mask);
    ch_mask      = mask;
    scan_trigger = 1'b1;
    sync();
    scan_trigger = 1'b0;
  endtask

  task automatic run_continuous(input logic [7:0] mask, input logic [15:0] gap, input int nscans);
    int per;
    int base;
    per  = $countones(mask & ~bad_mask);
    base = pops;
    ch_mask  = mask;
    scan_gap = gap;
    repeat (nscans) push_scan(mask);
    enable = 1'b1;
    wait_pops("cont_pops", base + (nscans - 1) * per, 5000);
    wait_start("cont_last_start", 1000);
    enable = 1'b0;
    wait_idle("cont_idle", 3000);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] m;
    for (int i = 0; i < 8; i++) adc_data[i] = 12'h100 + 12'(i);

    repeat (3) sync();
    @(negedge clk);
    check("reset_outputs", {measure_start, measure_ch, out_valid, out_data, out_ch, out_last,
                            busy, err_timeout, timeout_ch}, 32'h0);
    sync();
    reset = 1'b0;
    sync();
    @(negedge clk);
    check("idle_after_reset", {busy, measure_start, out_valid}, 3'b000);
    sync();

    // Empty mask: trigger is ignored.
    trigger_scan(8'h00);
    repeat (3) sync();
    check("empty_mask_ignored", busy, 1'b0);

    // Directed scan over channels 2, 5, 7 with 77-cycle conversions.
    push_scan(8'hA4);
    trigger_scan(8'hA4);
    wait_idle("scan_a4", 2000);
    check("idle_after_scan", busy, 1'b0);

    // Continuous single-channel scanning with a 10-cycle gap, then with no gap.
    adc_lat = 20;
    run_continuous(8'h01, 16'd10, 4);
    run_continuous(8'h01, 16'd0, 3);
    check("idle_after_continuous", busy, 1'b0);

    // Backpressure: hold out_ready low for 50 cycles from the first result.
    adc_lat = 30;
    for (int i = 0; i < 8; i++) adc_data[i] = 12'($urandom);
    out_ready = 1'b0;
    push_scan(8'h22);
    trigger_scan(8'h22);
    wait_valid("stall_first_valid", 200);
    repeat (50) sync();
    out_ready = 1'b1;
    wait_idle("stall_scan", 1000);

    // Channel 3 never completes: timeout, then channel 4 still converted as last.
    check("no_timeout_yet", err_timeout, 1'b0);
    bad_mask = 8'h08;
    for (int i = 0; i < 8; i++) adc_data[i] = 12'h100 + 12'(i);
    push_scan(8'h18);
    trigger_scan(8'h18);
    wait_idle("timeout_scan", 1000);
    check("timeout_flag", {err_timeout, timeout_ch}, {1'b1, 3'd3});
    bad_mask = 8'h00;

    // Random scans with random latency, backpressure, busy re-triggers and mid-scan mask changes.
    rand_lat   = 1'b1;
    rand_ready = 1'b1;
    for (int it = 0; it < 12; it++) begin
      m = 8'($urandom);
      if (m == 8'h00) m = 8'h80;
      for (int c = 0; c < 8; c++) adc_data[c] = 12'($urandom);
      push_scan(m);
      trigger_scan(m);
      sync();
      ch_mask      = 8'($urandom);
      scan_trigger = 1'b1;
      sync();
      scan_trigger = 1'b0;
      wait_idle("random_scan", 2000);
    end
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
    sync();
    out_ready = 1'b1;
    check("timeout_sticky", err_timeout, 1'b1);

    // Mask shrunk mid-scan has no effect; reset during a conversion returns everything to idle.
    adc_lat = 40;
    for (int i = 0; i < 8; i++) adc_data[i] = 12'h100 + 12'(i);
    push_scan(8'hFF);
    trigger_scan(8'hFF);
    wait_pops("mask_change_first", pops + 1, 500);
    sync();
    ch_mask = 8'h01;
    wait_pops("mask_change_second", pops + 1, 500);
    wait_start("mask_change_third_start", 500);
    repeat (10) sync();
    reset = 1'b1;
    sync();
    sync();
    exp_q.delete();
    @(negedge clk);
    check("reset_mid_conversion", {measure_start, measure_ch, out_valid, out_data, out_ch,
                                   out_last, busy, err_timeout, timeout_ch}, 32'h0);
    sync();
    reset = 1'b0;
    repeat (3) sync();
    check("idle_after_reset_release", {busy, out_valid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Scan controller that sequences the LTC2308 measurement core (measure_start / measure_ch / measure_done / measure_dataread) across a programmable set of channels. It issues one conversion at a time in ascending channel order and waits for completion, with a timeout. Each result is presented on a valid/ready output stream tagged with its channel and an end-of-scan marker. It sits between the ADC core and the downstream sample FIFO, in the same clk domain as the ADC core (≤40 MHz).

Parameters:
NUM_CH, 8, number of ADC channels; channel index width is 3.
DATA_W, 12, conversion result width.
TIMEOUT_CYCLES, 255, maximum clk cycles in WAIT_DONE before a conversion is abandoned.
GAP_W, 16, width of the inter-scan gap counter.

Ports:
clk  in  1  system clock, same clock as the ADC core.
reset  in  1  synchronous, active-high reset.
enable  in  1  continuous-scan enable.
scan_trigger  in  1  single-cycle pulse; starts one scan when in IDLE.
ch_mask  in  NUM_CH  enabled channels; bit i = channel i.
scan_gap  in  GAP_W  idle clk cycles between continuous scans.
measure_start  out  1  start pulse to the ADC core.
measure_ch  out  3  channel select to the ADC core.
measure_done  in  1  conversion complete, level signal from the ADC core.
measure_dataread  in  DATA_W  conversion result from the ADC core.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
out_data  out  DATA_W  result value.
out_ch  out  3  channel of the result.
out_last  out  1  result is the last channel of the scan.
busy  out  1  high in any state other than IDLE.
err_timeout  out  1  sticky; set on any timeout, cleared only by reset.
timeout_ch  out  3  channel of the most recent timeout.

Behaviour:
- Reset (synchronous): state=IDLE, measure_start=0, measure_ch=0, out_valid=0, out_data=0, out_ch=0, out_last=0, err_timeout=0, timeout_ch=0, gap counter=0.
- A scan starts from IDLE when (enable=1 or scan_trigger=1) and ch_mask≠0.
  - ch_mask is latched into scan_mask at that cycle. Changes to ch_mask mid-scan have no effect until the next scan.
  - ch_mask=0: remain in IDLE and ignore the trigger.
- The first channel is the lowest set bit of scan_mask. The next channel is the next higher set bit. last = no higher set bit exists.
- States:
  - IDLE -> START.
  - START: measure_start=1 for exactly 1 cycle; measure_ch holds the current channel. measure_ch is stable from START through WAIT_DONE. -> SETTLE.
  - SETTLE: measure_start=0 for 1 cycle. measure_done is not sampled here, so the stale done level is ignored. -> WAIT_DONE.
  - WAIT_DONE: on measure_done=1, register measure_dataread into out_data, set out_ch and out_last, assert out_valid -> PUSH.
    - Timeout: the cycle counter reaches TIMEOUT_CYCLES with no done. Set err_timeout and timeout_ch and produce no output.
    - After a timeout, go to START for the next channel if not last. If last, go to GAP or IDLE as for a completed scan.
  - PUSH: hold out_valid and the payload stable until out_valid&out_ready. On that cycle, drop out_valid.
    - Not last: -> START with the next channel.
    - Last and enable=1: -> GAP, loading the counter with scan_gap.
    - Last and enable=0: -> IDLE.
  - GAP: count down to 0, then -> START for a new scan (re-latch ch_mask). If ch_mask=0 at that point, -> IDLE.
    - scan_gap=0 gives zero extra cycles: GAP lasts 1 cycle.
    - If enable falls during GAP, -> IDLE on the next cycle.
- Backpressure: there is no internal buffering. The sequencer stalls in PUSH, so no result is ever dropped or overwritten.
- enable falling mid-scan: the current scan completes, then the sequencer returns to IDLE.
- scan_trigger while busy is ignored.
- reset mid-conversion: return to IDLE immediately. The ADC core's in-flight conversion is abandoned, and the next START restarts it.
- Throughput, per channel, with out_ready held high: 1 (START) + 1 (SETTLE) + ADC latency (~77 clk) + 1 (PUSH).

Test Plan:
- ch_mask=8'b1010_0100, scan_trigger pulse, out_ready=1, ADC model done after 77 cycles with data=0x100+ch -> outputs (ch2,0x102,last=0), (ch5,0x105,last=0), (ch7,0x107,last=1); then IDLE with busy=0.
- enable=1, ch_mask=8'h01, scan_gap=10 -> ch0 results repeat with exactly 10 GAP cycles plus 1 between PUSH completion and the next measure_start; every result has out_last=1.
- out_ready=0 for 50 cycles after the first out_valid -> out_valid, out_data and out_ch stay constant; no measure_start during the stall; the next channel starts 1 cycle after the handshake.
- ADC model never asserts done on ch3, mask=8'h18 -> after 255 cycles err_timeout=1, timeout_ch=3, no output for ch3; ch4 is then converted and output with last=1.
- Stale done: measure_done held high from the previous conversion through START/SETTLE, falling 1 cycle after start -> no spurious out_valid; the result is taken only on the new done rising.
- ch_mask changed from 8'hFF to 8'h01 mid-scan, then reset asserted in WAIT_DONE -> the scan continues on the original mask until reset; after reset all outputs are at their reset values and state=IDLE.
